// File: rtl/icache_assoc_access_unit.sv
// icache_assoc_access_unit
// N-way set-associative tag/data storage and lookup for the instruction cache.
// It provides a one-cycle registered lookup, victim selection for refills and
// single-cycle invalidate-all.
// Optional feature macro: ICACHE_PLRU_EN. When defined, each set uses a tree
// pseudo-LRU for replacement. When undefined, each set uses a round-robin pointer.

`ifndef CACHE_BLK_SIZE
`define CACHE_BLK_SIZE 128
`endif

module icache_assoc_access_unit #(
  parameter int CACHE_BLK_SIZE    = `CACHE_BLK_SIZE,
  parameter int CACHE_TAG_LEN     = 22,
  parameter int CACHE_GRP_NUM_LEN = 6,
  parameter int CACHE_WAYS        = 2,
  localparam int WAY_LEN          = $clog2(CACHE_WAYS)
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rstn,
  input  logic                         lookup_en,
  input  logic [CACHE_TAG_LEN-1:0]     addr_tag,
  input  logic [CACHE_GRP_NUM_LEN-1:0] addr_index,
  input  logic                         refill_we,
  input  logic [CACHE_BLK_SIZE-1:0]    refill_data,
  input  logic                         inv_all,
  output logic [WAY_LEN-1:0]           victim_way,
  output logic                         lookup_vld,
  output logic                         cache_hit,
  output logic [WAY_LEN-1:0]           hit_way,
  output logic [CACHE_BLK_SIZE-1:0]    cache_data_r
);

  localparam int SETS = 1 << CACHE_GRP_NUM_LEN;
`ifdef ICACHE_PLRU_EN
  localparam int REPL_W = CACHE_WAYS - 1;
`else
  localparam int REPL_W = WAY_LEN;
`endif

  // Storage arrays. Their contents are never reset.
  logic [CACHE_TAG_LEN-1:0]  tag_mem  [CACHE_WAYS][SETS];
  logic [CACHE_BLK_SIZE-1:0] data_mem [CACHE_WAYS][SETS];

  // Per-set valid bits and replacement state
  logic [CACHE_WAYS-1:0] valid_q [SETS];
  logic [CACHE_WAYS-1:0] valid_d [SETS];
  logic [REPL_W-1:0]     repl_q  [SETS];
  logic [REPL_W-1:0]     repl_d  [SETS];

  // Lookup result registers
  logic                      lkp_vld_q;
  logic [CACHE_WAYS-1:0]     vld_set_q;
  logic [CACHE_TAG_LEN-1:0]  tag_q;
  logic [CACHE_TAG_LEN-1:0]  rd_tag_q  [CACHE_WAYS];
  logic [CACHE_BLK_SIZE-1:0] rd_data_q [CACHE_WAYS];
`ifdef ICACHE_PLRU_EN
  logic                         upd_q;
  logic [CACHE_GRP_NUM_LEN-1:0] idx_q;
`endif

  logic                  refill_do;
  logic                  lookup_go;
  logic [CACHE_WAYS-1:0] set_vld;
  logic                  free_found;
  logic [WAY_LEN-1:0]    free_way;
  logic                  hit_any;
  logic [WAY_LEN-1:0]    hit_sel;

`ifdef ICACHE_PLRU_EN
  // Tree bits point toward the LRU side: bit0 is the root, bit1 is the left pair, bit2 is the right pair.
  function automatic logic [WAY_LEN-1:0] repl_victim(input logic [REPL_W-1:0] b);
    logic [2:0] t;
    logic [1:0] v;
    t = 3'(b);
    if (CACHE_WAYS == 2) v = {1'b0, t[0]};
    else                 v = {t[0], (t[0] ? t[2] : t[1])};
    return v[WAY_LEN-1:0];
  endfunction

  function automatic logic [REPL_W-1:0] plru_touch(input logic [REPL_W-1:0] b,
                                                   input logic [WAY_LEN-1:0] way);
    logic [2:0] t;
    logic [1:0] w;
    t = 3'(b);
    w = 2'(way);
    if (CACHE_WAYS == 2) begin
      t[0] = ~w[0];
    end else begin
      t[0] = ~w[1];
      if (w[1]) t[2] = ~w[0];
      else      t[1] = ~w[0];
    end
    return t[REPL_W-1:0];
  endfunction
`else
  function automatic logic [WAY_LEN-1:0] repl_victim(input logic [REPL_W-1:0] b);
    return b;
  endfunction
`endif

  // A refill takes priority over a lookup in the same cycle. Invalidate-all cancels a refill.
  assign refill_do = refill_we & ~inv_all;
  assign lookup_go = lookup_en & ~refill_we;
  assign set_vld   = valid_q[addr_index];

  // Victim choice: the lowest-index invalid way, otherwise the replacement-policy choice.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = CACHE_WAYS - 1; i >= 0; i--) begin
      if (!set_vld[i]) begin
        free_found = 1'b1;
        free_way   = WAY_LEN'(i);
      end
    end
    victim_way = free_found ? free_way : repl_victim(repl_q[addr_index]);
  end

  // Refill write into the selected victim way
  always_ff @(posedge cpu_clk) begin
    if (refill_do) begin
      tag_mem[victim_way][addr_index]  <= addr_tag;
      data_mem[victim_way][addr_index] <= refill_data;
    end
  end

  // ---- stage boundary: request -> lookup result (synchronous array read) ----
  // Read all ways of the indexed set and capture the request tag
  always_ff @(posedge cpu_clk) begin
    if (lookup_go) begin
      tag_q <= addr_tag;
      for (int w = 0; w < CACHE_WAYS; w++) begin
        rd_tag_q[w]  <= tag_mem[w][addr_index];
        rd_data_q[w] <= data_mem[w][addr_index];
      end
    end
  end

  // Lookup control: result-valid flag and a snapshot of the set's valid bits
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      lkp_vld_q <= 1'b0;
      vld_set_q <= '0;
    end else if (lookup_en) begin
      lkp_vld_q <= lookup_go;
      if (lookup_go) vld_set_q <= inv_all ? '0 : set_vld;
    end
  end

`ifdef ICACHE_PLRU_EN
  // One-cycle flag so that a held hit result updates the PLRU only once
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) upd_q <= 1'b0;
    else           upd_q <= lookup_go;
  end

  // Set index of the last issued lookup, used by the hit update
  always_ff @(posedge cpu_clk) begin
    if (lookup_go) idx_q <= addr_index;
  end
`endif

  // Tag compare. If more than one way hits, the lowest-index way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = CACHE_WAYS - 1; i >= 0; i--) begin
      if (vld_set_q[i] && (rd_tag_q[i] == tag_q)) begin
        hit_any = 1'b1;
        hit_sel = WAY_LEN'(i);
      end
    end
  end

  assign lookup_vld   = lkp_vld_q;
  assign cache_hit    = lkp_vld_q & hit_any;
  assign hit_way      = cache_hit ? hit_sel : '0;
  assign cache_data_r = cache_hit ? rd_data_q[hit_sel] : '0;

  // Next-state logic for valid bits and replacement state. Invalidate-all wins.
  always_comb begin
    valid_d = valid_q;
    repl_d  = repl_q;
    if (inv_all) begin
      for (int s = 0; s < SETS; s++) begin
        valid_d[s] = '0;
        repl_d[s]  = '0;
      end
    end else begin
`ifdef ICACHE_PLRU_EN
      if (upd_q && cache_hit) repl_d[idx_q] = plru_touch(repl_q[idx_q], hit_way);
`endif
      if (refill_we) begin
        valid_d[addr_index][victim_way] = 1'b1;
`ifdef ICACHE_PLRU_EN
        repl_d[addr_index] = plru_touch(repl_d[addr_index], victim_way);
`else
        if (&set_vld) repl_d[addr_index] = repl_q[addr_index] + REPL_W'(1);
`endif
      end
    end
  end

  // State register for valid bits and replacement state
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        repl_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      repl_q  <= repl_d;
    end
  end

endmodule

// File: tb/tb_icache_assoc_access_unit.sv
// Scoreboard testbench for icache_assoc_access_unit (2 ways, 64-bit blocks).
// Replacement expectations follow the ICACHE_PLRU_EN setting of the build.
module tb_icache_assoc_access_unit;

  localparam int BLK  = 64;
  localparam int TAGL = 22;
  localparam int IDXL = 6;
  localparam int SETS = 64;

  logic            cpu_clk = 1'b0;
  logic            cpu_rstn = 1'b0;
  logic            lookup_en = 1'b0;
  logic            refill_we = 1'b0;
  logic            inv_all = 1'b0;
  logic [TAGL-1:0] addr_tag = '0;
  logic [IDXL-1:0] addr_index = '0;
  logic [BLK-1:0]  refill_data = '0;
  logic [0:0]      victim_way;
  logic            lookup_vld;
  logic            cache_hit;
  logic [0:0]      hit_way;
  logic [BLK-1:0]  cache_data_r;

  icache_assoc_access_unit #(
    .CACHE_BLK_SIZE(BLK), .CACHE_TAG_LEN(TAGL), .CACHE_GRP_NUM_LEN(IDXL), .CACHE_WAYS(2)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .lookup_en(lookup_en), .addr_tag(addr_tag),
    .addr_index(addr_index), .refill_we(refill_we), .refill_data(refill_data),
    .inv_all(inv_all), .victim_way(victim_way), .lookup_vld(lookup_vld),
    .cache_hit(cache_hit), .hit_way(hit_way), .cache_data_r(cache_data_r)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic           vld;
    logic           hit;
    logic           way;
    logic [BLK-1:0] data;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0]      m_vld  [SETS];
  logic [TAGL-1:0] m_tag  [2][SETS];
  logic [BLK-1:0]  m_data [2][SETS];
  logic            m_repl [SETS];
  logic            m_pend;
  logic [IDXL-1:0] m_pidx;
  logic            m_pway;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [TAGL-1:0] TA = 22'h12345;
  localparam logic [TAGL-1:0] TB = 22'h2AAAA;
  localparam logic [TAGL-1:0] TC = 22'h0F0F0;
  localparam logic [TAGL-1:0] TD = 22'h3C3C3;
  localparam logic [TAGL-1:0] TE = 22'h00777;
  localparam logic [BLK-1:0]  DA = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [BLK-1:0]  DB = 64'h1122_3344_5566_7788;
  localparam logic [BLK-1:0]  DC = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [BLK-1:0]  DD = 64'h0123_4567_89AB_CDEF;

  task automatic check_eq(input string tag, input logic [BLK-1:0] got, input logic [BLK-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_victim(input logic [IDXL-1:0] idx);
    if (!m_vld[idx][0]) return 1'b0;
    if (!m_vld[idx][1]) return 1'b1;
    return m_repl[idx];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_vld[s]  = 2'b00;
      m_repl[s] = 1'b0;
    end
    m_pend = 1'b0;
  endtask

  // Drive one cycle, check victim_way, push the expected lookup result, step the model and compare.
  task automatic cyc(input logic lk, input logic rf, input logic inv,
                     input logic [TAGL-1:0] tag, input logic [IDXL-1:0] idx,
                     input logic [BLK-1:0] data);
    exp_t            e;
    logic            vw;
    logic            full;
    logic            pend_n;
    logic [IDXL-1:0] pidx_n;
    logic            pway_n;
    lookup_en   = lk;
    refill_we   = rf;
    inv_all     = inv;
    addr_tag    = tag;
    addr_index  = idx;
    refill_data = data;
    #1;
    vw = m_victim(idx);
    check_eq("victim_way", BLK'(victim_way), BLK'(vw));
    pend_n = 1'b0;
    pidx_n = idx;
    pway_n = 1'b0;
    if (lk) begin
      e = '0;
      if (inv) begin
        e.vld = 1'b1;
      end else if (!rf) begin
        e.vld = 1'b1;
        for (int w = 1; w >= 0; w--) begin
          if (m_vld[idx][w] && m_tag[w][idx] == tag) begin
            e.hit  = 1'b1;
            e.way  = w[0];
            e.data = m_data[w][idx];
          end
        end
        pend_n = e.hit;
        pway_n = e.way;
      end
      sb.push_back(e);
    end
    if (inv) begin
      for (int s = 0; s < SETS; s++) begin
        m_vld[s]  = 2'b00;
        m_repl[s] = 1'b0;
      end
    end else begin
`ifdef ICACHE_PLRU_EN
      if (m_pend) m_repl[m_pidx] = ~m_pway;
`endif
      if (rf) begin
        full = &m_vld[idx];
        m_tag[vw][idx]  = tag;
        m_data[vw][idx] = data;
        m_vld[idx][vw]  = 1'b1;
`ifdef ICACHE_PLRU_EN
        m_repl[idx] = ~vw;
`else
        if (full) m_repl[idx] = ~m_repl[idx];
`endif
      end
    end
    m_pend = pend_n;
    m_pidx = pidx_n;
    m_pway = pway_n;
    @(posedge cpu_clk);
    #1;
    if (lk) begin
      if (sb.size() == 0) begin
        check_eq("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("lookup_vld", BLK'(lookup_vld), BLK'(e.vld));
        check_eq("cache_hit", BLK'(cache_hit), BLK'(e.hit));
        check_eq("hit_way", BLK'(hit_way), BLK'(e.way));
        check_eq("cache_data_r", cache_data_r, e.data);
      end
    end
  endtask

  task automatic idle(input logic [IDXL-1:0] idx);
    cyc(1'b0, 1'b0, 1'b0, '0, idx, '0);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(posedge cpu_clk);
    #1;
    check_eq("rst_lookup_vld", BLK'(lookup_vld), 0);
    check_eq("rst_cache_hit", BLK'(cache_hit), 0);
    check_eq("rst_hit_way", BLK'(hit_way), 0);
    check_eq("rst_data", cache_data_r, 0);
    cpu_rstn = 1'b1;
    idle(5);

    // Lookup into an empty cache, then refill and hit
    cyc(1, 0, 0, TA, 5, '0);
    cyc(0, 1, 0, TA, 5, DA);
    cyc(1, 0, 0, TA, 5, '0);

    // Fill both ways, then a third refill into the full set
    idle(5);
    cyc(0, 1, 0, TB, 5, DB);
    cyc(0, 1, 0, TC, 5, DC);
    cyc(1, 0, 0, TC, 5, '0);
    cyc(1, 0, 0, TB, 5, '0);
    cyc(1, 0, 0, TA, 5, '0);

    // Same pattern on a fresh set with a hit on A before the third refill
    cyc(0, 1, 0, TA, 9, DA);
    cyc(0, 1, 0, TB, 9, DB);
    cyc(1, 0, 0, TA, 9, '0);
    idle(9);
    cyc(0, 1, 0, TC, 9, DC);
    cyc(1, 0, 0, TB, 9, '0);
    cyc(1, 0, 0, TC, 9, '0);
    cyc(1, 0, 0, TA, 9, '0);

    // Refill and lookup in the same cycle: the lookup is dropped
    cyc(1, 1, 0, TD, 12, DD);
    cyc(1, 0, 0, TD, 12, '0);

    // Invalidate-all with a lookup in the same cycle, then lookups miss
    cyc(1, 0, 1, TA, 5, '0);
    cyc(1, 0, 0, TA, 5, '0);
    cyc(1, 0, 0, TD, 12, '0);

    // Invalidate-all cancels a simultaneous refill
    cyc(0, 1, 1, TE, 30, DD);
    cyc(1, 0, 0, TE, 30, '0);

    // Asynchronous reset during a held hit
    cyc(0, 1, 0, TE, 20, DB);
    cyc(1, 0, 0, TE, 20, '0);
    #2;
    cpu_rstn = 1'b0;
    #1;
    check_eq("arst_lookup_vld", BLK'(lookup_vld), 0);
    check_eq("arst_cache_hit", BLK'(cache_hit), 0);
    check_eq("arst_hit_way", BLK'(hit_way), 0);
    check_eq("arst_data", cache_data_r, 0);
    lookup_en = 1'b0;
    refill_we = 1'b0;
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;
    model_reset();
    sb.delete();
    cyc(1, 0, 0, TE, 20, '0);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Overall time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
